// File: rtl/scrypt_scratch_resp.sv
// ============================================================================
// scrypt_scratch_resp
// ----------------------------------------------------------------------------
// Responder end of the smix scratchpad interface. A 1024-bit scratch_read or
// scratch_write request is carried out as a burst of 32-bit beats on a narrow
// single-port memory. Beat 0 carries the most significant 32 bits of the word.
//
// Optional feature (macro SCRATCH_ERR_EN):
//   Adds the output scratch_err, a sticky protocol-error flag. It is set when
//   the request changes mid-burst, or when read and write are both asserted
//   in IDLE. Only n_rst clears it.
//
// Ports:
//   clk            in   rising-edge system clock
//   n_rst          in   asynchronous active-low reset
//   scratch_read   in   read request (sampled in IDLE only)
//   scratch_write  in   write request (sampled in IDLE only, wins over read)
//   scratch_addr   in   scratch word address
//   scratch_in     in   write data word
//   scratch_out    out  word buffer (read result / last written word)
//   scratch_done   out  one-cycle completion pulse
//   mem_re         out  memory read strobe
//   mem_we         out  memory write strobe
//   mem_addr       out  {word address, beat index}
//   mem_wdata      out  memory write data
//   mem_rdata      in   memory read data, valid the cycle after mem_re
//   scratch_err    out  sticky error flag (SCRATCH_ERR_EN builds only)
// ============================================================================
module scrypt_scratch_resp #(
    parameter  int ADDR_BITS = 10,
    parameter  int WORD_BITS = 1024,
    parameter  int BEAT_BITS = 32,
    localparam int BEATS     = WORD_BITS / BEAT_BITS,
    localparam int BI        = $clog2(BEATS)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    scratch_read,
    input  logic                    scratch_write,
    input  logic [ADDR_BITS-1:0]    scratch_addr,
    input  logic [WORD_BITS-1:0]    scratch_in,
    output logic [WORD_BITS-1:0]    scratch_out,
    output logic                    scratch_done,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic [ADDR_BITS+BI-1:0] mem_addr,
    output logic [BEAT_BITS-1:0]    mem_wdata,
    input  logic [BEAT_BITS-1:0]    mem_rdata
`ifdef SCRATCH_ERR_EN
    ,
    output logic                    scratch_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_LAST,
        DONE
    } state_t;

    localparam logic [BI-1:0] LAST_BEAT = BI'(BEATS - 1);

    state_t               state;
    state_t               next_state;
    logic [BI-1:0]        beat;
    logic [ADDR_BITS-1:0] addr_q;
    logic [WORD_BITS-1:0] buffer;
    logic                 cap_valid;
    logic [BI-1:0]        cap_beat;
    logic [BI-1:0]        wr_slot;
    logic [BI-1:0]        cap_slot;

    // Beat b lives at word slot (BEATS-1-b), so beat 0 is the MS chunk.
    assign wr_slot  = LAST_BEAT - beat;
    assign cap_slot = LAST_BEAT - cap_beat;

    assign scratch_out = buffer;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobes and address come straight from the state, so a reset drops
    // them in the same instant, even in the middle of a burst.
    always_comb begin
        next_state   = state;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        scratch_done = 1'b0;
        case (state)
            IDLE: begin
                if (scratch_write) begin
                    next_state = WR;
                end else if (scratch_read) begin
                    next_state = RD;
                end
            end
            WR: begin
                mem_we    = 1'b1;
                mem_addr  = {addr_q, beat};
                mem_wdata = buffer[wr_slot*BEAT_BITS +: BEAT_BITS];
                if (beat == LAST_BEAT) begin
                    next_state = DONE;
                end
            end
            RD: begin
                mem_re   = 1'b1;
                mem_addr = {addr_q, beat};
                if (beat == LAST_BEAT) begin
                    next_state = RD_LAST;
                end
            end
            RD_LAST: begin
                next_state = DONE;
            end
            DONE: begin
                scratch_done = 1'b1;
                next_state   = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Read data returns one cycle after its strobe, so the beat index of each
    // strobe is remembered and used for the capture on the following edge.
    // RD_LAST exists only to land the final beat.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            beat      <= '0;
            addr_q    <= '0;
            buffer    <= '0;
            cap_valid <= 1'b0;
            cap_beat  <= '0;
        end else begin
            cap_valid <= (state == RD);
            cap_beat  <= beat;
            if (cap_valid) begin
                buffer[cap_slot*BEAT_BITS +: BEAT_BITS] <= mem_rdata;
            end
            case (state)
                IDLE: begin
                    if (scratch_write || scratch_read) begin
                        addr_q <= scratch_addr;
                        beat   <= '0;
                    end
                    if (scratch_write) begin
                        buffer <= scratch_in;
                    end
                end
                WR, RD: begin
                    if (beat != LAST_BEAT) begin
                        beat <= beat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SCRATCH_ERR_EN
    logic held_read;
    logic held_write;
    logic err_q;

    // The request pattern seen at acceptance must stay unchanged until the
    // burst has finished; DONE is exempt because the initiator drops the
    // request there.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            held_read  <= 1'b0;
            held_write <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (scratch_read || scratch_write) begin
                    held_read  <= scratch_read;
                    held_write <= scratch_write;
                end
                if (scratch_read && scratch_write) begin
                    err_q <= 1'b1;
                end
            end else if (state != DONE) begin
                if ((scratch_read != held_read) || (scratch_write != held_write) ||
                    (scratch_addr != addr_q)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign scratch_err = err_q;
`endif

endmodule

// File: tb/tb_scrypt_scratch_resp.sv
// ============================================================================
// tb_scrypt_scratch_resp
// ----------------------------------------------------------------------------
// Self-checking bench for scrypt_scratch_resp. A 32-bit memory sits behind the
// DUT, and a word-level scratchpad model holds what each scratch address
// should contain. Directed scenarios run first, followed by random
// read/write traffic.
// ============================================================================
module tb_scrypt_scratch_resp;

    localparam int AB = 10;
    localparam int WB = 1024;
    localparam int BB = 32;
    localparam int NB = WB / BB;

    logic            clk;
    logic            n_rst;
    logic            scratch_read;
    logic            scratch_write;
    logic [AB-1:0]   scratch_addr;
    logic [WB-1:0]   scratch_in;
    logic [WB-1:0]   scratch_out;
    logic            scratch_done;
    logic            mem_re;
    logic            mem_we;
    logic [AB+4:0]   mem_addr;
    logic [BB-1:0]   mem_wdata;
    logic [BB-1:0]   mem_rdata;
`ifdef SCRATCH_ERR_EN
    logic            scratch_err;
`endif

    int compared   = 0;
    int mismatched = 0;
    int max_addr   = 0;

    logic [BB-1:0] mem [0:(1<<(AB+5))-1];
    logic [WB-1:0] ref_words [int];

    scrypt_scratch_resp dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .scratch_read  (scratch_read),
        .scratch_write (scratch_write),
        .scratch_addr  (scratch_addr),
        .scratch_in    (scratch_in),
        .scratch_out   (scratch_out),
        .scratch_done  (scratch_done),
        .mem_re        (mem_re),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
`ifdef SCRATCH_ERR_EN
        ,
        .scratch_err   (scratch_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Narrow synchronous SRAM: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    function automatic logic [WB-1:0] refRead(input int a);
        if (ref_words.exists(a)) return ref_words[a];
        return '0;
    endfunction

    function automatic logic [WB-1:0] randomWord();
        logic [WB-1:0] w;
        for (int i = 0; i < NB; i++) w[i*BB +: BB] = $urandom;
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [WB-1:0] observed,
                               input logic [WB-1:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One complete request: drive it, watch every burst cycle, compare the
    // strobe counts, addresses, data and completion timing with the model.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [AB-1:0] addr,
                                 input logic [WB-1:0] data);
        int we_cnt = 0, re_cnt = 0, good_we = 0, good_re = 0, both_cnt = 0, done_at = 0;
        int slot;
        logic [AB+4:0] exp_addr;
        logic [WB-1:0] exp_word;
        @(negedge clk);
        checkOutput("idle_done_low", scratch_done, 0);
        checkOutput("idle_strobes", {mem_re, mem_we}, 0);
        scratch_write = wr;
        scratch_read  = rd;
        scratch_addr  = addr;
        scratch_in    = data;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            exp_addr = {addr, 5'(cyc - 1)};
            slot     = NB - cyc;
            if (mem_we) begin
                we_cnt++;
                if (cyc <= NB && mem_addr == exp_addr && mem_wdata == data[slot*BB +: BB])
                    good_we++;
            end
            if (mem_re) begin
                re_cnt++;
                if (cyc <= NB && mem_addr == exp_addr) good_re++;
            end
            if (mem_re && mem_we) both_cnt++;
            if ((mem_re || mem_we) && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            if (scratch_done) begin
                done_at = cyc;
                break;
            end
        end
        exp_word = wr ? data : refRead(int'(addr));
        if (wr) ref_words[int'(addr)] = data;
        checkOutput("done_cycle", done_at, wr ? 33 : 34);
        checkOutput("we_cycles", we_cnt, wr ? NB : 0);
        checkOutput("we_good_beats", good_we, wr ? NB : 0);
        checkOutput("re_cycles", re_cnt, wr ? 0 : NB);
        checkOutput("re_good_beats", good_re, wr ? 0 : NB);
        checkOutput("strobe_overlap", both_cnt, 0);
        checkOutput("scratch_out", scratch_out, exp_word);
        scratch_write = 1'b0;
        scratch_read  = 1'b0;
    endtask

    // Pull reset while beat 10 of a write is on the bus; beats 0..9 have
    // already reached memory, the rest of the old word survives.
    task automatic resetDuringWrite(input logic [AB-1:0] addr, input logic [WB-1:0] data);
        logic [WB-1:0] old;
        logic          activity = 1'b0;
        old = refRead(int'(addr));
        @(negedge clk);
        scratch_write = 1'b1;
        scratch_addr  = addr;
        scratch_in    = data;
        repeat (11) @(negedge clk);
        checkOutput("pre_reset_addr", mem_addr, {addr, 5'd10});
        checkOutput("pre_reset_we", mem_we, 1);
        n_rst = 1'b0;
        #1;
        checkOutput("reset_we_low", mem_we, 0);
        checkOutput("reset_done_low", scratch_done, 0);
        checkOutput("reset_out_zero", scratch_out, 0);
        scratch_write = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (scratch_done || mem_we || mem_re) activity = 1'b1;
        end
        checkOutput("no_done_after_reset", activity, 0);
        ref_words[int'(addr)] = {data[WB-1:WB-10*BB], old[WB-10*BB-1:0]};
    endtask

    initial begin
        logic [WB-1:0]   w;
        logic [AB-1:0]   pool [6];
        pool = '{10'd3, 10'd5, 10'd7, 10'd100, 10'd512, 10'd1023};

        for (int i = 0; i < (1 << (AB + 5)); i++) mem[i] = '0;
        n_rst         = 1'b0;
        scratch_read  = 1'b0;
        scratch_write = 1'b0;
        scratch_addr  = '0;
        scratch_in    = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_scratch_out", scratch_out, 0);
        checkOutput("rst_done", scratch_done, 0);
        checkOutput("rst_strobes", {mem_re, mem_we}, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
`ifdef SCRATCH_ERR_EN
        checkOutput("rst_err", scratch_err, 0);
`endif
        n_rst = 1'b1;

        // Beat b of the word carries value b.
        for (int b = 0; b < NB; b++) w[(NB-1-b)*BB +: BB] = BB'(b);
        applyStimulus(1'b1, 1'b0, 10'd5, w);
        applyStimulus(1'b0, 1'b1, 10'd5, '0);

        max_addr = 0;
        applyStimulus(1'b1, 1'b0, 10'd1023, '1);
        checkOutput("max_mem_addr", max_addr, 32767);
        applyStimulus(1'b0, 1'b1, 10'd0, randomWord());

        applyStimulus(1'b1, 1'b1, 10'd7, randomWord());
`ifdef SCRATCH_ERR_EN
        checkOutput("err_both_req", scratch_err, 1);
`endif
        applyStimulus(1'b0, 1'b1, 10'd7, '0);

        resetDuringWrite(10'd5, randomWord());
        applyStimulus(1'b0, 1'b1, 10'd5, '0);

        applyStimulus(1'b1, 1'b0, 10'd2, randomWord());
        applyStimulus(1'b0, 1'b1, 10'd2, '0);

        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 1) == 1)
                applyStimulus(1'b1, 1'b0, pool[$urandom_range(0, 5)], randomWord());
            else
                applyStimulus(1'b0, 1'b1, pool[$urandom_range(0, 5)], randomWord());
        end

        @(negedge clk);
        checkOutput("final_done_low", scratch_done, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
